apb_cmd_master: RTL

//   APB4 initiator for the peripheral bus: turns one valid/ready command (addr, write, data, strobe)

---
 rtl/apb_cmd_master_pkg.sv | 16 +
 rtl/apb_cmd_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master.
// Holds the transfer sequencer state encoding and the idle values driven onto the APB outputs.
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [3:0]  PSTRB_NONE    = 4'b0000;
    localparam logic [2:0]  PPROT_DEFAULT = 3'b000;
    localparam logic [31:0] DATA_ZERO     = 32'h0000_0000;

endpackage

// File: rtl/apb_cmd_master.sv
// APB4 initiator: one valid/ready command becomes one SETUP+ACCESS transfer with a valid/ready response.
// A single outstanding transfer; an optional wait-state timeout aborts slaves that never raise PREADY.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDRWIDTH = 16,
    parameter int TIMEOUT   = 255,
    parameter int TOWIDTH   = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,
    input  logic [2:0]           cmd_prot,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam logic [ADDRWIDTH-1:0] ADDR_MASK = {{(ADDRWIDTH-2){1'b1}}, 2'b00};
    localparam logic [TOWIDTH-1:0]   TO_LIMIT  = TOWIDTH'(TIMEOUT);
    localparam logic [TOWIDTH-1:0]   WAIT_MAX  = {TOWIDTH{1'b1}};
    localparam logic                 TO_ENABLE = (TIMEOUT != 0);

    state_e                 state_q;
    logic                   cmd_ready_q;
    logic                   psel_q;
    logic                   penable_q;
    logic [ADDRWIDTH-1:0]   paddr_q;
    logic                   pwrite_q;
    logic [31:0]            pwdata_q;
    logic [3:0]             pstrb_q;
    logic [2:0]             pprot_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_rdata_q;
    logic                   rsp_err_q;
    logic                   rsp_timeout_q;
    logic [TOWIDTH-1:0]     wait_q;

    logic [TOWIDTH-1:0]     wait_d;
    logic                   timeout_hit;
    logic                   cmd_fire;
    logic                   rsp_fire;

    assign cmd_fire = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
    assign rsp_fire = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;

    // Wait counter saturates rather than wrapping, so a disabled timeout never aliases back to zero.
    assign wait_d      = (wait_q == WAIT_MAX) ? wait_q : wait_q + TOWIDTH'(1);
    assign timeout_hit = TO_ENABLE && (wait_d == TO_LIMIT);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= DATA_ZERO;
            pstrb_q       <= PSTRB_NONE;
            pprot_q       <= PPROT_DEFAULT;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= DATA_ZERO;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        state_q     <= ST_SETUP;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        paddr_q     <= cmd_addr & ADDR_MASK;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_write ? cmd_wdata : DATA_ZERO;
                        pstrb_q     <= cmd_write ? cmd_strb : PSTRB_NONE;
                        pprot_q     <= cmd_prot;
                        wait_q      <= '0;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= (!pwrite_q && !PSLVERR) ? PRDATA : DATA_ZERO;
                        state_q       <= ST_RESP;
                    end else begin
                        wait_q <= wait_d;
                        // Abandoning the slave mid-transfer is accepted; the bus is simply released.
                        if (timeout_hit) begin
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            rsp_rdata_q   <= DATA_ZERO;
                            state_q       <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;

endmodule
